// File: rtl/beta_pkg.sv
// Shared types and constants for the beta hazard controller.
// Holds the FSM state type, the latched request bundle and x0.
package beta_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       uses1;
        logic       uses2;
        logic       rd_wr;
    } hz_req_t;

    // Embedded parts track x0..x15 only; bit 4 of every address is dropped.
    function automatic logic [4:0] reg_idx(input logic [4:0] a,
                                           input bit emb);
        return emb ? {1'b0, a[3:0]} : a;
    endfunction

endpackage

// File: rtl/beta_hazard_ctrl_if.sv
// Decode/writeback/hazard bundle between the decoder and the hazard unit.
// master = decoder/execute side, slave = hazard controller side.
interface beta_hazard_ctrl_if #(
    parameter int StallCntWidth = 16
);
    logic                     dec_new_instr;
    logic [4:0]               dec_rsrc1_addr;
    logic [4:0]               dec_rsrc2_addr;
    logic                     dec_uses_rs1;
    logic                     dec_uses_rs2;
    logic [4:0]               dec_rd_addr;
    logic                     dec_rd_wr;
    logic                     exe_wb_valid;
    logic [4:0]               exe_wb_addr;
    logic                     hz_flush;
    logic                     hz_stall;
    logic                     hz_issue;
    logic                     hz_forward_en;
    logic [1:0]               hz_forward_src;
    logic [31:0]              hz_pending;
    logic [StallCntWidth-1:0] hz_stall_cnt;

    modport master (
        output dec_new_instr, dec_rsrc1_addr, dec_rsrc2_addr,
        output dec_uses_rs1, dec_uses_rs2, dec_rd_addr, dec_rd_wr,
        output exe_wb_valid, exe_wb_addr, hz_flush,
        input  hz_stall, hz_issue, hz_forward_en, hz_forward_src,
        input  hz_pending, hz_stall_cnt
    );

    modport slave (
        input  dec_new_instr, dec_rsrc1_addr, dec_rsrc2_addr,
        input  dec_uses_rs1, dec_uses_rs2, dec_rd_addr, dec_rd_wr,
        input  exe_wb_valid, exe_wb_addr, hz_flush,
        output hz_stall, hz_issue, hz_forward_en, hz_forward_src,
        output hz_pending, hz_stall_cnt
    );
endinterface

// File: rtl/beta_scoreboard.sv
// Pending-write vector: one bit per register with an outstanding write.
// Ports: set/clear (addr+enable), flush, pending_o. Set wins over clear.
module beta_scoreboard
    import beta_pkg::*;
#(
    parameter int unsigned Embedded = 0
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        set_en_i,
    input  logic [4:0]  set_addr_i,
    input  logic        clr_en_i,
    input  logic [4:0]  clr_addr_i,
    input  logic        flush_i,
    output logic [31:0] pending_o
);

    logic [31:0] pending_q;
    logic [31:0] pending_d;

    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        // Applied after the clear so a same-cycle set survives.
        if (set_en_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[REG_X0] = 1'b0;
        if (Embedded != 0) begin
            pending_d[31:16] = '0;
        end
        if (flush_i) begin
            pending_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/beta_hazard_ctrl.sv
// In-order issue hazard control: RAW/WAW detection, writeback forwarding,
// stall FSM and stall counter. Ports: decode request, writeback, flush in;
// issue/stall/forward/pending/stall count out.
module beta_hazard_ctrl
    import beta_pkg::*;
#(
    parameter int unsigned Embedded      = 0,
    parameter int          StallCntWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     dec_new_instr_i,
    input  logic [4:0]               dec_rsrc1_addr_i,
    input  logic [4:0]               dec_rsrc2_addr_i,
    input  logic                     dec_uses_rs1_i,
    input  logic                     dec_uses_rs2_i,
    input  logic [4:0]               dec_rd_addr_i,
    input  logic                     dec_rd_wr_i,
    input  logic                     exe_wb_valid_i,
    input  logic [4:0]               exe_wb_addr_i,
    input  logic                     hz_flush_i,
    output logic                     hz_stall_o,
    output logic                     hz_issue_o,
    output logic                     hz_forward_en_o,
    output logic [1:0]               hz_forward_src_o,
    output logic [31:0]              hz_pending_o,
    output logic [StallCntWidth-1:0] hz_stall_cnt_o
);

    localparam bit Emb = (Embedded != 0);

    hz_state_t state_q, state_d;
    hz_req_t   req_q, req_d;
    hz_req_t   live, cur;

    logic [StallCntWidth-1:0] cnt_q, cnt_d;
    logic [31:0] pending;
    logic [4:0]  wb_addr;
    logic        active;
    logic        fwd1, fwd2;
    logic        raw1, raw2, waw;
    logic        wb_rd;
    logic        hazard;
    logic        issue, stall;
    logic        set_en;

    always_comb begin
        live       = '0;
        live.rs1   = reg_idx(dec_rsrc1_addr_i, Emb);
        live.rs2   = reg_idx(dec_rsrc2_addr_i, Emb);
        live.rd    = reg_idx(dec_rd_addr_i, Emb);
        live.uses1 = dec_uses_rs1_i;
        live.uses2 = dec_uses_rs2_i;
        live.rd_wr = dec_rd_wr_i;
    end

    // While stalled the held copy is authoritative; decode is ignored.
    assign cur     = (state_q == STALL) ? req_q : live;
    assign wb_addr = reg_idx(exe_wb_addr_i, Emb);
    // Gating with rstn_i keeps all outputs low during reset.
    assign active  = rstn_i & ((state_q == STALL) | dec_new_instr_i);

    assign fwd1 = cur.uses1 & (cur.rs1 != REG_X0)
                & exe_wb_valid_i & (wb_addr == cur.rs1);
    assign fwd2 = cur.uses2 & (cur.rs2 != REG_X0)
                & exe_wb_valid_i & (wb_addr == cur.rs2);

    assign raw1 = cur.uses1 & (cur.rs1 != REG_X0)
                & pending[cur.rs1] & ~fwd1;
    assign raw2 = cur.uses2 & (cur.rs2 != REG_X0)
                & pending[cur.rs2] & ~fwd2;

    assign wb_rd = exe_wb_valid_i & (wb_addr == cur.rd);
    assign waw   = cur.rd_wr & (cur.rd != REG_X0)
                 & pending[cur.rd] & ~wb_rd;

    assign hazard = raw1 | raw2 | waw;
    assign issue  = active & ~hazard & ~hz_flush_i;
    assign stall  = active &  hazard & ~hz_flush_i;

    assign hz_issue_o       = issue;
    assign hz_stall_o       = stall;
    assign hz_forward_src_o = issue ? {fwd2, fwd1} : 2'b00;
    assign hz_forward_en_o  = issue & (fwd1 | fwd2);
    assign hz_pending_o     = pending;
    assign hz_stall_cnt_o   = cnt_q;

    assign set_en = issue & cur.rd_wr & (cur.rd != REG_X0);

    beta_scoreboard #(
        .Embedded (Embedded)
    ) u_sb (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .set_en_i   (set_en),
        .set_addr_i (cur.rd),
        .clr_en_i   (exe_wb_valid_i),
        .clr_addr_i (wb_addr),
        .flush_i    (hz_flush_i),
        .pending_o  (pending)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (1'b1)
            hz_flush_i: begin
                state_d = IDLE;
                req_d   = '0;
            end
            (state_q == IDLE) && stall: begin
                state_d = STALL;
                req_d   = live;
            end
            (state_q == STALL) && issue: begin
                state_d = IDLE;
                req_d   = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/beta_hazard_ctrl.md
BETA_HAZARD_CTRL -- requirements
Module: beta_hazard_ctrl

Interface
REQ-001 SHALL have parameter Embedded, default 0: 1 = 16 tracked registers and address bit 4 ignored; 0 = 32 tracked registers.
REQ-002 SHALL have parameter StallCntWidth, default 16: width of the stall-cycle counter.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port dec_new_instr_i, input, 1 bit: one-cycle pulse, a new decoded instruction is presented.
REQ-006 SHALL have ports dec_rsrc1_addr_i and dec_rsrc2_addr_i, input, 5 bits each: decoded source register addresses.
REQ-007 SHALL have ports dec_uses_rs1_i and dec_uses_rs2_i, input, 1 bit each: the instruction reads rs1 or rs2.
REQ-008 SHALL have ports dec_rd_addr_i (input, 5 bits) and dec_rd_wr_i (input, 1 bit): destination register and its write intent.
REQ-009 SHALL have ports exe_wb_valid_i (input, 1 bit) and exe_wb_addr_i (input, 5 bits): regfile writeback this cycle.
REQ-010 SHALL have port hz_flush_i, input, 1 bit: exception or redirect; discard all pending state.
REQ-011 SHALL have port hz_stall_o, output, 1 bit: the presented instruction cannot issue this cycle.
REQ-012 SHALL have port hz_issue_o, output, 1 bit: one-cycle pulse, the instruction issues this cycle.
REQ-013 SHALL have ports hz_forward_en_o (output, 1 bit) and hz_forward_src_o (output, 2 bits): bit0 forwards to operand A, bit1 to operand B.
REQ-014 SHALL have port hz_pending_o, output, 32 bits: scoreboard vector; unused bits are 0.
REQ-015 SHALL have port hz_stall_cnt_o, output, StallCntWidth bits: saturating count of stalled cycles.

Function
REQ-016 SHALL use two states: IDLE (no held request) and STALL (request latched, waiting for the hazard to clear).
REQ-017 SHALL evaluate the live decode inputs in IDLE and the latched copy (rs1, rs2, rd, uses, rd_wr) in STALL.
REQ-018 SHALL set fwd_srcN = uses_rsN & rsN!=0 & exe_wb_valid_i & exe_wb_addr_i==rsN.
REQ-019 SHALL set the RAW hazard on N = uses_rsN & rsN!=0 & pending[rsN] & !fwd_srcN.
REQ-020 SHALL set the WAW hazard = rd_wr & rd!=0 & pending[rd] & !(exe_wb_valid_i & exe_wb_addr_i==rd).
REQ-021 SHALL assert hz_issue_o combinationally when the request is active (IDLE with dec_new_instr_i, or STALL), no hazard exists and hz_flush_i is 0.
REQ-022 SHALL drive hz_forward_en_o = hz_issue_o & |fwd_src, and hz_forward_src_o = fwd_src gated by hz_issue_o.
REQ-023 SHALL drive hz_stall_o = request active & any hazard & !hz_flush_i.
REQ-024 SHALL, on a stall in IDLE, latch the request and enter STALL at the next edge; on issue in STALL, return to IDLE.
REQ-025 SHALL ignore dec_new_instr_i while in STALL; upstream holds the instruction because hz_stall_o is high.
REQ-026 SHALL, at the edge after an issue with rd_wr & rd!=0, set pending[rd].
REQ-027 SHALL, at the edge after exe_wb_valid_i, clear pending[exe_wb_addr_i].
REQ-028 SHALL, when a set and a clear hit the same register in the same cycle, leave it set.
REQ-029 SHALL never set pending[0]; a writeback to x0 has no effect.
REQ-030 SHALL, on hz_flush_i, clear all pending bits, enter IDLE and drop the latched request at the next edge, and suppress issue, stall and forward that cycle; flush has priority over every other event.
REQ-031 SHALL increment hz_stall_cnt_o on each cycle hz_stall_o=1, saturating at all-ones; flush does not clear it.

Reset
REQ-032 SHALL, while rstn_i=0, asynchronously force state to IDLE, pending to 0, the latched request to 0 and hz_stall_cnt_o to 0.
REQ-033 SHALL drive every output to 0 while rstn_i=0; a reset that arrives in STALL discards the held request.

Structure
REQ-034 SHALL place hz_state_t (IDLE, STALL) and the constant REG_X0 = 5'd0 in beta_pkg.
REQ-035 SHALL instantiate one sub-module, beta_scoreboard, which holds the pending vector with set, clear and flush ports and applies set-over-clear priority.
REQ-036 SHALL keep the hazard, forward and FSM logic in beta_hazard_ctrl.

Verification
REQ-037 SHALL cover: issue rd=5, then next instruction uses rs1=5 with no writeback -> hz_stall_o=1 for each cycle until writeback addr 5, then hz_issue_o=1 with hz_forward_src_o=2'b01.
REQ-038 SHALL cover: pending[7]=1, instruction with rs2=7 presented in the writeback cycle for 7 -> same-cycle issue, hz_forward_en_o=1, hz_forward_src_o=2'b10, no stall.
REQ-039 SHALL cover: instruction with rs1=0, rd=0 and pending all 0 -> issue, hz_pending_o stays 32'h0.
REQ-040 SHALL cover: pending[3]=1, instruction with rd=3 and no writeback -> WAW stall; writeback 3 -> issue in that cycle, pending[3]=1 afterwards.
REQ-041 SHALL cover: in STALL with pending[9]=1, hz_flush_i=1 -> next cycle state IDLE, hz_pending_o=0, no hz_issue_o pulse.
REQ-042 SHALL cover: rstn_i=0 asserted mid-STALL between clock edges -> all outputs 0 immediately, hz_stall_cnt_o=0; and StallCntWidth=2 with 5 stall cycles -> counter holds 3.
